mmio_uart_tx: RTL and testbench

//  Memory-mapped UART transmitter on the processor data bus, beside the zero-delay RAM; consumes

---
 rtl/uart_tx_pkg.sv | 13 +
 rtl/uart_tx_fifo.sv | 32 +++
 rtl/mmio_uart_tx.sv | 133 +++++++++++++
 tb/tb_mmio_uart_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: FSM state type and status bit positions for mmio_uart_tx.
// UART_TX_PARITY_EN adds the PARITY state to the encoding.
package uart_tx_pkg;
`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} tx_state_t;
`endif
    localparam int FULL_B  = 0;
    localparam int EMPTY_B = 1;
    localparam int BUSY_B  = 2;
    localparam int OVF_B   = 3;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: power-of-two FIFO with extra-MSB pointers; head entry visible combinationally.
// Unaffected by UART_TX_PARITY_EN.
module uart_tx_fifo #(
    parameter int Width = 8,
    parameter int Depth = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(Depth);
    logic [Width-1:0] mem [Depth];
    logic [AW:0] wr_ptr, rd_ptr;
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
    always_ff @(posedge clock) if (push) mem[wr_ptr[AW-1:0]] <= wdata;
    assign rdata = mem[rd_ptr[AW-1:0]];
    assign empty = wr_ptr == rd_ptr;
    assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
endmodule

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: store-driven UART transmitter with FIFO, sticky overflow and status register.
// Frames are 8N1; defining UART_TX_PARITY_EN makes them 8E1.
module mmio_uart_tx
    import uart_tx_pkg::*;
#(
    parameter int dataW                   = 32,
    parameter int RAMAddrSize             = 16,
    parameter logic [RAMAddrSize-1:0] TxDataAddr = 16'hFFF0,
    parameter logic [RAMAddrSize-1:0] TxStatAddr = 16'hFFF4,
    parameter int ClksPerBit              = 868,
    parameter int FifoDepth               = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [RAMAddrSize-1:0] RAMAddr,
    input  logic [dataW-1:0]       DataIn,
    input  logic                   RAMWriteControl,
    input  logic                   InsCacheStall,
    output logic [dataW-1:0]       StatusOut,
    output logic                   StatusHit,
    output logic                   TxOut,
    output logic                   TxBusy
);
    localparam int BW = $clog2(ClksPerBit);
    localparam logic [BW-1:0] BAUD_MAX = BW'(ClksPerBit - 1);
    tx_state_t state, state_n;
    logic [BW-1:0] baud, baud_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] data, data_n, rdata;
    logic tx, tx_n, ovf, ovf_n;
    logic we, push_req, push, pop, full, empty, bit_done;
    assign we = RAMWriteControl & ~InsCacheStall;
    assign push_req = we && RAMAddr == TxDataAddr;
    assign push = push_req && !full;
    // an overflow in the same cycle as a clear leaves the flag set
    assign ovf_n = (push_req && full) ? 1'b1 :
                   (we && RAMAddr == TxStatAddr && DataIn[3]) ? 1'b0 : ovf;
    assign bit_done = baud == '0;
    uart_tx_fifo #(.Width(8), .Depth(FifoDepth)) u_fifo (
        .clock(clock),
        .reset(reset),
        .push(push),
        .pop(pop),
        .wdata(DataIn[7:0]),
        .rdata(rdata),
        .full(full),
        .empty(empty)
    );
    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            baud    <= '0;
            bit_cnt <= '0;
            data    <= '0;
            tx      <= 1'b1;
            ovf     <= 1'b0;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_cnt <= bit_cnt_n;
            data    <= data_n;
            tx      <= tx_n;
            ovf     <= ovf_n;
        end
    end
    always_comb begin
        state_n   = state;
        baud_n    = bit_done ? baud : baud - BW'(1);
        bit_cnt_n = bit_cnt;
        data_n    = data;
        tx_n      = tx;
        pop       = 1'b0;
        case (state)
            IDLE: if (!empty) begin
                pop     = 1'b1;
                data_n  = rdata;
                tx_n    = 1'b0;
                baud_n  = BAUD_MAX;
                state_n = START;
            end
            START: if (bit_done) begin
                baud_n    = BAUD_MAX;
                bit_cnt_n = 3'd0;
                tx_n      = data[0];
                state_n   = DATA;
            end
            DATA: if (bit_done) begin
                baud_n    = BAUD_MAX;
                bit_cnt_n = bit_cnt + 3'd1;
                tx_n      = data[bit_cnt + 3'd1];
                if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    tx_n    = ^data;
                    state_n = PARITY;
`else
                    tx_n    = 1'b1;
                    state_n = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_done) begin
                baud_n  = BAUD_MAX;
                tx_n    = 1'b1;
                state_n = STOP;
            end
`endif
            // chain straight into the next start bit when more data is queued
            STOP: if (bit_done) begin
                if (!empty) begin
                    pop     = 1'b1;
                    data_n  = rdata;
                    tx_n    = 1'b0;
                    baud_n  = BAUD_MAX;
                    state_n = START;
                end else begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end
    always_comb begin
        StatusOut          = '0;
        StatusOut[FULL_B]  = full;
        StatusOut[EMPTY_B] = empty;
        StatusOut[BUSY_B]  = state != IDLE;
        StatusOut[OVF_B]   = ovf;
    end
    assign StatusHit = RAMAddr == TxStatAddr && !InsCacheStall;
    assign TxOut = tx;
    assign TxBusy = state != IDLE;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: vector table, directed frame/overflow/reset sequences and randomized traffic
// checked against a queue-based line model; honours UART_TX_PARITY_EN.
module tb_mmio_uart_tx;
    localparam int CPB = 4;
    localparam int FD = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [15:0] addr = '0;
    logic [31:0] data = '0;
    logic wr = 1'b0;
    logic stall = 1'b0;
    logic [31:0] status;
    logic hit, tx, busy;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mmio_uart_tx #(.ClksPerBit(CPB), .FifoDepth(FD)) dut (
        .clock(clk),
        .reset(rst),
        .RAMAddr(addr),
        .DataIn(data),
        .RAMWriteControl(wr),
        .InsCacheStall(stall),
        .StatusOut(status),
        .StatusHit(hit),
        .TxOut(tx),
        .TxBusy(busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [NBITS-1:0] frame_of(input logic [7:0] b);
`ifdef UART_TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {1'b1, b, 1'b0};
`endif
    endfunction

    // Line model: a byte queue plus the per-clock waveform of the frame in flight.
    logic [7:0] mq[$];
    logic sched[$];
    logic m_tx = 1'b1, m_busy = 1'b0, m_ovf = 1'b0;

    always @(posedge clk) begin
        logic [NBITS-1:0] f;
        logic push_req;
        int n;
        if (rst) begin
            mq.delete();
            sched.delete();
            m_tx = 1'b1;
            m_busy = 1'b0;
            m_ovf = 1'b0;
        end else begin
            n = mq.size();
            push_req = wr && !stall && addr == 16'hFFF0;
            if (sched.size() == 0 && n > 0) begin
                f = frame_of(mq.pop_front());
                for (int i = 0; i < NBITS; i++) repeat (CPB) sched.push_back(f[i]);
            end
            m_busy = sched.size() > 0;
            m_tx = m_busy ? sched.pop_front() : 1'b1;
            if (push_req && n < FD) mq.push_back(data[7:0]);
            else if (push_req) m_ovf = 1'b1;
            else if (wr && !stall && addr == 16'hFFF4 && data[3]) m_ovf = 1'b0;
        end
    end

    function automatic logic [31:0] m_status();
        return {28'b0, m_ovf, m_busy, mq.size() == 0, mq.size() == FD};
    endfunction

    always @(negedge clk) if (chk_en) begin
        check("mon_tx", 32'(tx), 32'(m_tx));
        check("mon_busy", 32'(busy), 32'(m_busy));
        check("mon_status", status, m_status());
        check("mon_hit", 32'(hit), 32'(addr == 16'hFFF4 && !stall));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [15:0] a, input logic [31:0] d, input logic w, input logic s);
        addr = a;
        data = d;
        wr = w;
        stall = s;
    endtask

    task automatic idle();
        drive(16'h0000, 32'h0, 1'b0, 1'b0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy || !status[1]) && n < 20 * FRAME) begin
            tick();
            n++;
        end
        if (busy || !status[1]) begin
            tests++;
            fails++;
            $display("FAIL wait_idle: timeout busy=%0b status=%h expected idle", busy, status);
        end
    endtask

    task automatic send_and_check(input logic [7:0] b);
        logic [NBITS-1:0] f;
        f = frame_of(b);
        drive(16'hFFF0, {24'h0, b}, 1'b1, 1'b0);
        tick();
        idle();
        check("pre_start_tx", 32'(tx), 32'd1);
        for (int k = 0; k < FRAME; k++) begin
            tick();
            check($sformatf("frame_%02h_clk%0d", b, k), 32'(tx), 32'(f[k / CPB]));
        end
        tick();
        check("post_frame_status", status, 32'h2);
        check("post_frame_tx", 32'(tx), 32'd1);
    endtask

    typedef struct {
        logic [15:0] a;
        logic [31:0] d;
        logic w;
        logic s;
        logic hit;
        logic [31:0] st;
    } vec_t;
    vec_t tbl[10];

    initial begin
        int t0, n, sel, push_pct;
        logic [15:0] ra;
        tbl[0] = '{16'hFFF8, 32'h55, 1'b1, 1'b0, 1'b0, 32'h2};
        tbl[1] = '{16'hFFF0, 32'h55, 1'b1, 1'b1, 1'b0, 32'h2};
        tbl[2] = '{16'hFFF4, 32'h0, 1'b0, 1'b0, 1'b1, 32'h2};
        tbl[3] = '{16'hFFF4, 32'h0, 1'b0, 1'b1, 1'b0, 32'h2};
        tbl[4] = '{16'hFFF0, 32'h55, 1'b0, 1'b0, 1'b0, 32'h2};
        tbl[5] = '{16'hFFF4, 32'h8, 1'b1, 1'b0, 1'b1, 32'h2};
        tbl[6] = '{16'hFFF4, 32'h0, 1'b1, 1'b1, 1'b0, 32'h2};
        tbl[7] = '{16'hFFF0, 32'hA5, 1'b1, 1'b0, 1'b0, 32'h0};
        tbl[8] = '{16'h0000, 32'h0, 1'b0, 1'b0, 1'b0, 32'h6};
        tbl[9] = '{16'hFFF4, 32'h8, 1'b1, 1'b0, 1'b1, 32'h6};

        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        chk_en = 1'b1;
        check("reset_tx", 32'(tx), 32'd1);
        check("reset_status", status, 32'h2);
        check("reset_busy", 32'(busy), 32'd0);

        foreach (tbl[i]) begin
            drive(tbl[i].a, tbl[i].d, tbl[i].w, tbl[i].s);
            #1;
            check($sformatf("vec%0d_hit", i), 32'(hit), 32'(tbl[i].hit));
            tick();
            check($sformatf("vec%0d_status", i), status, tbl[i].st);
        end
        idle();
        wait_idle();

        send_and_check(8'h55);
`ifdef UART_TX_PARITY_EN
        send_and_check(8'h07);
`endif

        drive(16'hFFF0, 32'h3C, 1'b1, 1'b0);
        tick();
        t0 = cyc;
        idle();
        tick();
        tick();
        tick();
        for (int i = 0; i < 9; i++) begin
            drive(16'hFFF0, 32'h80 + i, 1'b1, 1'b0);
            tick();
        end
        idle();
        check("ovf_status", status, 32'hD);
        drive(16'hFFF4, 32'h7, 1'b1, 1'b0);
        tick();
        check("ovf_noclear", status, 32'hD);
        drive(16'hFFF4, 32'h8, 1'b1, 1'b0);
        tick();
        check("ovf_clear", status, 32'h5);
        idle();
        n = 0;
        while (busy && n < 12 * FRAME) begin
            tick();
            n++;
        end
        check("b2b_len", 32'(cyc - t0), 32'(9 * FRAME + 1));
        wait_idle();

        drive(16'hFFF0, 32'hC3, 1'b1, 1'b0);
        tick();
        drive(16'hFFF0, 32'h5A, 1'b1, 1'b0);
        tick();
        idle();
        repeat (15) tick();
        rst = 1'b1;
        tick();
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_status", status, 32'h2);
        check("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 3 * FRAME; k++) begin
            tick();
            check("midrst_line_idle", 32'(tx), 32'd1);
        end
        check("midrst_final_status", status, 32'h2);

        for (int c = 0; c < 6000; c++) begin
            push_pct = ((c / 1000) % 2 == 1) ? 60 : 8;
            sel = $urandom_range(0, 3);
            ra = sel == 0 ? 16'hFFF0 : sel == 1 ? 16'hFFF4 : sel == 2 ? 16'hFFF8 : 16'($urandom);
            drive(ra, $urandom, $urandom_range(0, 99) < push_pct, $urandom_range(0, 4) == 0);
            rst = $urandom_range(0, 1499) == 0;
            tick();
        end
        rst = 1'b0;
        idle();
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
